// File: rtl/flash_pkg.sv
// Types and helpers shared by the flash read responder, its read master and their benches.
package flash_pkg;
  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] MAX_ADDR = 23'h7FFFF;

  typedef enum logic {IDLE, STALL} fsm_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
  } rd_req_t;

  // The MSB half-word carries a marker bit so the player can tell halves apart.
  function automatic logic [DATA_W-1:0] pattern_word(input logic [ADDR_W-1:0] a);
    return {1'b1, a[14:0], 1'b0, a[14:0]};
  endfunction

  function automatic logic [DATA_W-1:0] format_word(input rd_req_t req);
    logic [DATA_W-1:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{req.be[b]}};
    return (req.addr > MAX_ADDR) ? '0 : (pattern_word(req.addr) & mask);
  endfunction
endpackage

// File: rtl/flash_read_pipe.sv
// Fixed-latency response pipe; the last data stage only loads on a valid,
// so the returned word holds between pulses.
module flash_read_pipe
  import flash_pkg::*;
#(
  parameter int unsigned LAT = 3
) (
  input  logic              CLK50MHZ,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);
  logic [LAT-1:0]             vld_pipe, vld_in;
  logic [LAT-1:0][DATA_W-1:0] dat_pipe, dat_in;

  always_comb begin
    vld_in    = '0;
    dat_in    = '0;
    vld_in[0] = in_valid;
    dat_in[0] = in_data;
    for (int i = 1; i < int'(LAT); i++) begin
      vld_in[i] = vld_pipe[i-1];
      dat_in[i] = dat_pipe[i-1];
    end
  end

  always_ff @(posedge CLK50MHZ or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe <= vld_in;
      for (int i = 0; i < int'(LAT); i++)
        if (vld_in[i]) dat_pipe[i] <= dat_in[i];
    end
  end

  assign out_valid = vld_pipe[LAT-1];
  assign out_data  = dat_pipe[LAT-1];
endmodule

// File: rtl/flash_read_responder.sv
// Avalon-MM read responder standing in for the flash controller: programmable
// wait-request stall, pipelined fixed-latency reads, address-derived data.
module flash_read_responder
  import flash_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter int unsigned READ_LATENCY = 3
) (
  input  logic              CLK50MHZ,
  input  logic              reset,
  input  logic              flash_mem_read,
  input  logic [ADDR_W-1:0] flash_mem_address,
  input  logic [3:0]        flash_mem_byteenable,
  output logic              flash_mem_waitrequest,
  output logic              flash_mem_readdatavalid,
  output logic [DATA_W-1:0] flash_mem_readdata,
  output logic [15:0]       read_count,
  output logic              addr_err,
  output logic              protocol_err
);
  localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

  fsm_state_e state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       accept_now, drop_now;
  rd_req_t    req;

  assign req = '{addr: flash_mem_address, be: flash_mem_byteenable};

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    accept_now   = 1'b0;
    drop_now     = 1'b0;
    case (state)
      IDLE: if (flash_mem_read) begin
        if (WAIT_N == 4'd0) accept_now = 1'b1;
        else begin
          wait_cnt_nxt = 4'd1;
          state_nxt    = STALL;
        end
      end
      STALL: begin
        if (!flash_mem_read) begin
          // Master gave up mid-stall: nothing is transferred.
          drop_now     = 1'b1;
          wait_cnt_nxt = 4'd0;
          state_nxt    = IDLE;
        end else if (wait_cnt == WAIT_N) begin
          accept_now   = 1'b1;
          wait_cnt_nxt = 4'd0;
          state_nxt    = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign flash_mem_waitrequest = flash_mem_read & ~accept_now;

  always_ff @(posedge CLK50MHZ or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      read_count   <= '0;
      addr_err     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept_now) read_count <= read_count + 16'd1;
      if (accept_now && (req.addr > MAX_ADDR)) addr_err <= 1'b1;
      if (drop_now) protocol_err <= 1'b1;
    end
  end

  flash_read_pipe #(.LAT(READ_LATENCY)) u_pipe (
    .CLK50MHZ  (CLK50MHZ),
    .reset     (reset),
    .in_valid  (accept_now),
    .in_data   (format_word(req)),
    .out_valid (flash_mem_readdatavalid),
    .out_data  (flash_mem_readdata)
  );
endmodule

// File: tb/tb_flash_read_responder.sv
// Randomized bench for two responders (WAIT_CYCLES=2 and 0) against a
// response-queue model keyed on accept cycle.
module tb_flash_read_responder;
  localparam int W0 = 2, W1 = 0, LAT = 3;

  logic        CLK50MHZ = 1'b0;
  logic [1:0]  rst, rd, wr, rdv, aerr, perr;
  logic [22:0] addr_in [2];
  logic [3:0]  be_in [2];
  logic [31:0] rdata [2];
  logic [15:0] cnt [2];

  int n_chk = 0, n_fail = 0, cyc = 0;

  // expected response queues, per instance
  logic [31:0] q_data [2][64];
  int          q_due [2][64];
  int          q_head [2], q_tail [2];
  logic [31:0] last_data [2];
  logic [15:0] exp_cnt [2];
  logic [1:0]  exp_aerr, exp_perr;
  logic        mon_ev;

  always #10 CLK50MHZ = ~CLK50MHZ;
  always @(posedge CLK50MHZ) cyc <= cyc + 1;

  flash_read_responder #(.WAIT_CYCLES(W0), .READ_LATENCY(LAT)) dut0 (
    .CLK50MHZ(CLK50MHZ), .reset(rst[0]), .flash_mem_read(rd[0]),
    .flash_mem_address(addr_in[0]), .flash_mem_byteenable(be_in[0]),
    .flash_mem_waitrequest(wr[0]), .flash_mem_readdatavalid(rdv[0]),
    .flash_mem_readdata(rdata[0]), .read_count(cnt[0]),
    .addr_err(aerr[0]), .protocol_err(perr[0]));

  flash_read_responder #(.WAIT_CYCLES(W1), .READ_LATENCY(LAT)) dut1 (
    .CLK50MHZ(CLK50MHZ), .reset(rst[1]), .flash_mem_read(rd[1]),
    .flash_mem_address(addr_in[1]), .flash_mem_byteenable(be_in[1]),
    .flash_mem_waitrequest(wr[1]), .flash_mem_readdatavalid(rdv[1]),
    .flash_mem_readdata(rdata[1]), .read_count(cnt[1]),
    .addr_err(aerr[1]), .protocol_err(perr[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int wc(input int i);
    return (i == 0) ? W0 : W1;
  endfunction

  // Expected word from plain arithmetic: high half 0x8000+P, low half P.
  function automatic logic [31:0] model_word(input logic [22:0] a, input logic [3:0] b);
    int unsigned p, w;
    if (int'(a) > 524287) return 32'h0;
    p = int'(a) % 32768;
    w = (32'h8000 + p) * 65536 + p;
    for (int k = 0; k < 4; k++)
      if (!b[k]) w = w & ~(32'hFF << (8 * k));
    return w;
  endfunction

  task automatic model_reset(input int i);
    q_head[i] = q_tail[i];
    last_data[i] = '0;
    exp_cnt[i] = '0;
    exp_aerr[i] = 1'b0;
    exp_perr[i] = 1'b0;
  endtask

  task automatic status(input int i);
    chk("read_count", 32'(cnt[i]), 32'(exp_cnt[i]));
    chk("addr_err", 32'(aerr[i]), 32'(exp_aerr[i]));
    chk("protocol_err", 32'(perr[i]), 32'(exp_perr[i]));
  endtask

  // Drive a read now and hold it until accepted; returns just after the accept edge.
  task automatic issue(input int i, input logic [22:0] a, input logic [3:0] b);
    int n = 0;
    rd[i] = 1'b1; addr_in[i] = a; be_in[i] = b;
    #1;
    while (wr[i] && n < 40) begin
      n++;
      @(negedge CLK50MHZ); #3;
    end
    chk("stall_len", 32'(n), 32'(wc(i)));
    if (!wr[i]) begin
      q_data[i][q_tail[i] % 64] = model_word(a, b);
      q_due[i][q_tail[i] % 64]  = cyc + LAT;
      q_tail[i]++;
      exp_cnt[i]++;
      if (int'(a) > 524287) exp_aerr[i] = 1'b1;
    end
    @(posedge CLK50MHZ); #1;
    rd[i] = 1'b0;
  endtask

  task automatic do_read(input int i, input logic [22:0] a, input logic [3:0] b);
    @(negedge CLK50MHZ); #2;
    issue(i, a, b);
  endtask

  task automatic drop_read();
    @(negedge CLK50MHZ); #2;
    rd[0] = 1'b1; addr_in[0] = 23'($urandom_range(0, 32'h7FFFF));
    #1 chk("drop_wr", 32'(wr[0]), 32'd1);
    @(posedge CLK50MHZ); #1;
    rd[0] = 1'b0;
    @(posedge CLK50MHZ); #1;
    exp_perr[0] = 1'b1;
    status(0);
  endtask

  task automatic rand_reads(input int i, input int n);
    logic [22:0] a;
    for (int k = 0; k < n; k++) begin
      if (i == 0 && $urandom_range(0, 9) == 0) drop_read();
      a = ($urandom_range(0, 4) == 0) ? 23'($urandom_range(32'h80000, 32'h7FFFFF))
                                      : 23'($urandom_range(0, 32'h7FFFF));
      do_read(i, a, 4'($urandom_range(0, 15)));
      status(i);
      repeat ($urandom_range(0, 2)) @(posedge CLK50MHZ);
    end
  endtask

  // Every cycle: a pulse exactly when the oldest response is due, word held otherwise.
  always @(negedge CLK50MHZ) begin
    for (int i = 0; i < 2; i++) begin
      mon_ev = (q_head[i] != q_tail[i]) && (q_due[i][q_head[i] % 64] == cyc);
      chk(i == 0 ? "rdv0" : "rdv1", 32'(rdv[i]), 32'(mon_ev));
      if (mon_ev) begin
        last_data[i] = q_data[i][q_head[i] % 64];
        q_head[i]++;
      end
      chk(i == 0 ? "rdata0" : "rdata1", rdata[i], last_data[i]);
    end
  end

  initial begin
    rst = 2'b11; rd = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr_in[i] = '0; be_in[i] = '0; q_head[i] = 0; q_tail[i] = 0;
      model_reset(i);
    end
    repeat (2) @(negedge CLK50MHZ);
    #2;
    // read asserted while still in reset
    rd[0] = 1'b1; addr_in[0] = 23'h00012; be_in[0] = 4'hF;
    #1;
    chk("rst_wr", 32'(wr[0]), 32'd1);
    chk("rst_wr_idle", 32'(wr[1]), 32'd0);
    status(0);
    status(1);
    rst = 2'b00;
    issue(0, 23'h00012, 4'hF);
    repeat (4) @(posedge CLK50MHZ);
    #1 status(0);

    do_read(0, 23'h00005, 4'b0011);
    repeat (4) @(posedge CLK50MHZ);

    // drop during stall from a clean state
    @(negedge CLK50MHZ); #2;
    rst[0] = 1'b1; model_reset(0);
    @(negedge CLK50MHZ); #2;
    rst[0] = 1'b0;
    drop_read();
    repeat (6) @(posedge CLK50MHZ);
    #1 status(0);

    do_read(0, 23'h080000, 4'hF);
    for (int k = 0; k < 10; k++) do_read(0, 23'($urandom_range(0, 32'h7FFFF)), 4'hF);
    repeat (4) @(posedge CLK50MHZ);
    #1 status(0);
    rand_reads(0, 40);

    // zero-wait instance: back-to-back, then again with reset behind it
    do_read(1, 23'h7FFFF, 4'hF);
    do_read(1, 23'h00000, 4'hF);
    repeat (5) @(posedge CLK50MHZ);
    #1 status(1);
    do_read(1, 23'h7FFFF, 4'hF);
    do_read(1, 23'h00000, 4'hF);
    @(negedge CLK50MHZ); #2;
    rst[1] = 1'b1; model_reset(1);
    #1 status(1);
    @(negedge CLK50MHZ); #2;
    rst[1] = 1'b0;
    repeat (5) @(posedge CLK50MHZ);
    #1 status(1);
    rand_reads(1, 40);

    repeat (LAT + 3) @(posedge CLK50MHZ);
    #1 status(0);
    status(1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
